nios_fprint_scratchpad_dp: RTL and testbench

Parametrised dual-slave scratchpad RAM for the fingerprinting Nios cores. Slave s1 serves the CPU data master; slave s2 serves a second master, such as the fingerprint/DMA unit.
- Both slaves share one single-port memory array through a per-cycle arbiter.
- Both slaves support waitrequest, pipelined readdatavalid, byte-lane writes, and clock-enable/reset_req gating.
- An optional post-reset clear engine zeroes the array so that fingerprint comparisons start from a deterministic state.

---
 rtl/nios_fprint_scratchpad_dp.sv | 160 ++++++++++++++++
 tb/tb_nios_fprint_scratchpad_dp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_fprint_scratchpad_dp.sv
// Dual-slave scratchpad RAM: two Avalon-style slaves share one single-port array
// through a per-cycle arbiter, with an optional post-reset zero-fill engine.
module nios_fprint_scratchpad_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int DEPTH          = 4096,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ARB_MODE       = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,
    output logic                    busy
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam bit ARB_FIXED = (ARB_MODE == 1);
    localparam bit LAT2 = (READ_LATENCY == 2);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  last_s2_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  en, run, req1, req2, grant1, grant2;
    logic                  acc_any, acc_wr, acc_rd, in_range;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [BE_W-1:0]       acc_be;
    logic [DATA_WIDTH-1:0] acc_wdata, rd_word;

    logic                  vld_p0, vld_p1, sel_p0, sel_p1;
    logic [DATA_WIDTH-1:0] rd_data_p0, rd_data_p1;
    logic [DATA_WIDTH-1:0] s1_rdata_q, s2_rdata_q;
    logic                  fin_vld_d, fin_sel_d, out_vld, out_sel;
    logic [DATA_WIDTH-1:0] fin_data_d;

    assign en   = clken & ~reset_req;
    assign run  = (state_q == ST_RUN);
    assign req1 = s1_chipselect & (s1_read | s1_write);
    assign req2 = s2_chipselect & (s2_read | s2_write);

    // Without a pointer bias (fixed mode) s1 wins ties; otherwise the slave not served last.
    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        if (run && en) begin
            grant1 = req1 & (~req2 | ARB_FIXED | last_s2_q);
            grant2 = req2 & ~grant1;
        end
    end

    assign acc_any   = grant1 | grant2;
    assign acc_addr  = grant2 ? s2_address    : s1_address;
    assign acc_be    = grant2 ? s2_byteenable : s1_byteenable;
    assign acc_wdata = grant2 ? s2_writedata  : s1_writedata;
    assign acc_wr    = grant2 ? s2_write      : s1_write;
    assign acc_rd    = acc_any & ~acc_wr;
    assign in_range  = {1'b0, acc_addr} < DEPTH_W;
    assign rd_word   = in_range ? mem[acc_addr] : '0;

    assign s1_waitrequest = ~run | (req1 & ~grant1);
    assign s2_waitrequest = ~run | (req2 & ~grant2);
    assign busy           = ~run;

    // Word entering the final read stage on this edge, chosen by latency.
    assign fin_vld_d  = LAT2 ? vld_p0     : acc_rd;
    assign fin_sel_d  = LAT2 ? sel_p0     : grant2;
    assign fin_data_d = LAT2 ? rd_data_p0 : rd_word;
    assign out_vld    = LAT2 ? vld_p1     : vld_p0;
    assign out_sel    = LAT2 ? sel_p1     : sel_p0;

    // Valid is shown only in an enabled cycle so a stalled pipeline never repeats a pulse.
    assign s1_readdatavalid = en & out_vld & ~out_sel;
    assign s2_readdatavalid = en & out_vld & out_sel;
    assign s1_readdata      = s1_rdata_q;
    assign s2_readdata      = s2_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q  <= '0;
            last_s2_q  <= 1'b1;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            sel_p0     <= 1'b0;
            sel_p1     <= 1'b0;
            s1_rdata_q <= '0;
            s2_rdata_q <= '0;
        end else if (en) begin
            if (state_q == ST_CLEAR) begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_q <= ST_RUN;
                end else begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                end
            end
            if (acc_any) begin
                last_s2_q <= grant2;
            end
            // stage p0 -> p1
            vld_p0 <= acc_rd;
            sel_p0 <= grant2;
            vld_p1 <= vld_p0;
            sel_p1 <= sel_p0;
            if (fin_vld_d) begin
                if (fin_sel_d) begin
                    s2_rdata_q <= fin_data_d;
                end else begin
                    s1_rdata_q <= fin_data_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            rd_data_p0 <= rd_word;
            rd_data_p1 <= rd_data_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (state_q == ST_CLEAR) begin
                mem[clr_cnt_q] <= '0;
            end else if (acc_any && acc_wr && in_range) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (acc_be[i]) begin
                        mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nios_fprint_scratchpad_dp.sv
// Directed bench: instance 0 uses default parameters, instance 1 uses
// DEPTH=3000, READ_LATENCY=2, fixed-priority arbitration.
module tb_nios_fprint_scratchpad_dp;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        clken     [2];
    logic        reset_req [2];
    logic [11:0] s1_addr [2], s2_addr [2];
    logic [3:0]  s1_be   [2], s2_be   [2];
    logic        s1_cs   [2], s2_cs   [2];
    logic        s1_rd   [2], s2_rd   [2];
    logic        s1_wr   [2], s2_wr   [2];
    logic [31:0] s1_wd   [2], s2_wd   [2];
    logic [31:0] s1_rdd  [2], s2_rdd  [2];
    logic        s1_rv   [2], s2_rv   [2];
    logic        s1_wt   [2], s2_wt   [2];
    logic        busy    [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cnt, tot, rvc;

    always #5 clk = ~clk;

    nios_fprint_scratchpad_dp u_a (
        .clk(clk), .reset_n(rst_n[0]), .clken(clken[0]), .reset_req(reset_req[0]),
        .s1_address(s1_addr[0]), .s1_byteenable(s1_be[0]), .s1_chipselect(s1_cs[0]),
        .s1_read(s1_rd[0]), .s1_write(s1_wr[0]), .s1_writedata(s1_wd[0]),
        .s1_readdata(s1_rdd[0]), .s1_readdatavalid(s1_rv[0]), .s1_waitrequest(s1_wt[0]),
        .s2_address(s2_addr[0]), .s2_byteenable(s2_be[0]), .s2_chipselect(s2_cs[0]),
        .s2_read(s2_rd[0]), .s2_write(s2_wr[0]), .s2_writedata(s2_wd[0]),
        .s2_readdata(s2_rdd[0]), .s2_readdatavalid(s2_rv[0]), .s2_waitrequest(s2_wt[0]),
        .busy(busy[0])
    );

    nios_fprint_scratchpad_dp #(
        .DEPTH(3000), .READ_LATENCY(2), .ARB_MODE(1)
    ) u_b (
        .clk(clk), .reset_n(rst_n[1]), .clken(clken[1]), .reset_req(reset_req[1]),
        .s1_address(s1_addr[1]), .s1_byteenable(s1_be[1]), .s1_chipselect(s1_cs[1]),
        .s1_read(s1_rd[1]), .s1_write(s1_wr[1]), .s1_writedata(s1_wd[1]),
        .s1_readdata(s1_rdd[1]), .s1_readdatavalid(s1_rv[1]), .s1_waitrequest(s1_wt[1]),
        .s2_address(s2_addr[1]), .s2_byteenable(s2_be[1]), .s2_chipselect(s2_cs[1]),
        .s2_read(s2_rd[1]), .s2_write(s2_wr[1]), .s2_writedata(s2_wd[1]),
        .s2_readdata(s2_rdd[1]), .s2_readdatavalid(s2_rv[1]), .s2_waitrequest(s2_wt[1]),
        .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic s1_op(input int d, input logic r, input logic w, input logic [11:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        s1_cs[d] = r | w; s1_rd[d] = r; s1_wr[d] = w;
        s1_addr[d] = a; s1_wd[d] = wd; s1_be[d] = be;
    endtask

    task automatic s2_op(input int d, input logic r, input logic w, input logic [11:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        s2_cs[d] = r | w; s2_rd[d] = r; s2_wr[d] = w;
        s2_addr[d] = a; s2_wd[d] = wd; s2_be[d] = be;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; clken[d] = 1'b1; reset_req[d] = 1'b0;
            s1_op(d, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
            s2_op(d, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        end
        #3;
        chk("rst_busy_a", busy[0], 1'b1);
        chk("rst_wait_noreq_a", s1_wt[0], 1'b1);
        chk("rst_rv_a", s1_rv[0], 1'b0);
        chk("rst_rdata_a", s1_rdd[0], 32'h0);
        chk("rst_rdata_b", s2_rdd[1], 32'h0);

        // Clear after reset, s1 holding a read of 0x005
        s1_op(0, 1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
        #1;
        chk("rst_wait_req_a", s1_wt[0], 1'b1);
        nxt();
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1;
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            if (!busy[0]) break;
            if (s1_wt[0]) cnt++;
            nxt(); #1;
        end
        chk("clear_len_a", cnt, 4096);
        chk("clear_done_busy", busy[0], 1'b0);
        chk("clear_accept_wait", s1_wt[0], 1'b0);
        nxt();
        s1_op(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        chk("clear_rv", s1_rv[0], 1'b1);
        chk("clear_rdata", s1_rdd[0], 32'h0);

        // Byte lanes, read-after-write from the other slave
        nxt();
        s1_op(0, 1'b0, 1'b1, 12'h010, 32'hAABBCCDD, 4'hF);
        #1;
        chk("wr1_wait", s1_wt[0], 1'b0);
        nxt();
        s1_op(0, 1'b0, 1'b1, 12'h010, 32'h11223344, 4'h5);
        nxt();
        s1_op(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        s2_op(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        #1;
        chk("be_rd_wait", s2_wt[0], 1'b0);
        nxt();
        s2_op(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        chk("be_rv", s2_rv[0], 1'b1);
        chk("be_rdata", s2_rdd[0], 32'hAA22CC44);
        chk("be_s1_hold", s1_rdd[0], 32'h0);

        // Round-robin contention: s2 writes 0x020, then both read for 4 cycles
        nxt();
        s2_op(0, 1'b0, 1'b1, 12'h020, 32'h12345678, 4'hF);
        nxt();
        s1_op(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        s2_op(0, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                s1_op(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
                s2_op(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
            end
            #1;
            if (c < 4) begin
                chk($sformatf("rr_wait1_c%0d", c), s1_wt[0], (c % 2 == 1));
                chk($sformatf("rr_wait2_c%0d", c), s2_wt[0], (c % 2 == 0));
            end
            chk($sformatf("rr_rv1_c%0d", c), s1_rv[0], (c == 1 || c == 3));
            chk($sformatf("rr_rv2_c%0d", c), s2_rv[0], (c == 2 || c == 4));
            if (c == 1 || c == 3) chk($sformatf("rr_rd1_c%0d", c), s1_rdd[0], 32'hAA22CC44);
            if (c == 2 || c == 4) chk($sformatf("rr_rd2_c%0d", c), s2_rdd[0], 32'h12345678);
            nxt();
        end

        // Latency 2 with clken gated for 3 cycles after acceptance
        s1_op(1, 1'b0, 1'b1, 12'h020, 32'h5A5A5A5A, 4'hF);
        nxt();
        s1_op(1, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
        #1;
        chk("lat_accept", s1_wt[1], 1'b0);
        nxt();
        s1_op(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        s2_op(1, 1'b1, 1'b0, 12'h000, 32'h0, 4'h0);
        clken[1] = 1'b0;
        #1;
        chk("gate_wait2", s2_wt[1], 1'b1);
        chk("lat_rv_t1", s1_rv[1], 1'b0);
        nxt();
        s2_op(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        chk("lat_rv_t2", s1_rv[1], 1'b0);
        nxt(); #1;
        chk("lat_rv_t3", s1_rv[1], 1'b0);
        nxt();
        clken[1] = 1'b1;
        #1;
        chk("lat_rv_t4", s1_rv[1], 1'b0);
        nxt(); #1;
        chk("lat_rv_t5", s1_rv[1], 1'b1);
        chk("lat_rdata", s1_rdd[1], 32'h5A5A5A5A);
        nxt(); #1;
        chk("lat_rv_t6", s1_rv[1], 1'b0);

        // Out-of-range write then read returns 0 with valid
        s1_op(1, 1'b0, 1'b1, 12'hC00, 32'hFFFFFFFF, 4'hF);
        #1;
        chk("oor_wr_wait", s1_wt[1], 1'b0);
        nxt();
        s1_op(1, 1'b1, 1'b0, 12'hC00, 32'h0, 4'h0);
        nxt();
        s1_op(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        chk("oor_rv_t1", s1_rv[1], 1'b0);
        nxt(); #1;
        chk("oor_rv_t2", s1_rv[1], 1'b1);
        chk("oor_rdata", s1_rdd[1], 32'h0);

        // Read and write together is a write with no valid
        nxt();
        s1_op(1, 1'b1, 1'b1, 12'h001, 32'hCAFEF00D, 4'hF);
        nxt();
        s1_op(1, 1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
        #1;
        chk("rw_rv_t1", s1_rv[1], 1'b0);
        nxt();
        s1_op(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        chk("rw_rv_t2", s1_rv[1], 1'b0);
        nxt(); #1;
        chk("rw_rv_t3", s1_rv[1], 1'b1);
        chk("rw_rdata", s1_rdd[1], 32'hCAFEF00D);

        // Fixed priority: s1 wins every tie
        nxt();
        s1_op(1, 1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
        s2_op(1, 1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
        #1;
        chk("fp_c0_wait1", s1_wt[1], 1'b0);
        chk("fp_c0_wait2", s2_wt[1], 1'b1);
        nxt(); #1;
        chk("fp_c1_wait1", s1_wt[1], 1'b0);
        chk("fp_c1_wait2", s2_wt[1], 1'b1);
        nxt();
        s1_op(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        chk("fp_c2_wait2", s2_wt[1], 1'b0);
        chk("fp_c2_rv1", s1_rv[1], 1'b1);
        nxt();
        s2_op(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        chk("fp_c3_rv1", s1_rv[1], 1'b1);
        chk("fp_c3_rv2", s2_rv[1], 1'b0);
        nxt(); #1;
        chk("fp_c4_rv2", s2_rv[1], 1'b1);
        chk("fp_c4_rd2", s2_rdd[1], 32'hCAFEF00D);

        // Reset one cycle after an accepted read, then a paused clear
        nxt(); nxt();
        s1_op(1, 1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
        #1;
        chk("mr_accept", s1_wt[1], 1'b0);
        nxt();
        s1_op(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        rst_n[1] = 1'b0;
        #1;
        chk("mr_rv", s1_rv[1], 1'b0);
        chk("mr_busy", busy[1], 1'b1);
        chk("mr_wait_noreq", s1_wt[1], 1'b1);
        nxt(); nxt();
        rst_n[1] = 1'b1;
        #1;
        cnt = 0; tot = 0; rvc = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!busy[1]) break;
            tot++;
            if (!reset_req[1]) cnt++;
            if (s1_rv[1] || s2_rv[1]) rvc++;
            nxt();
            reset_req[1] = (i >= 99 && i < 104);
            #1;
        end
        chk("mr_clear_en_cycles", cnt, 3000);
        chk("mr_clear_tot_cycles", tot, 3005);
        chk("mr_no_valid", rvc, 0);
        chk("mr_rdata_reset", s1_rdd[1], 32'h0);
        chk("mr_busy_done", busy[1], 1'b0);
        s1_op(1, 1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
        nxt();
        s1_op(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        nxt(); #1;
        chk("mr_cleared_rv", s1_rv[1], 1'b1);
        chk("mr_cleared_rdata", s1_rdd[1], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
